wsacc_window_gen: RTL and testbench
===================================

WSACC_WINDOW_GEN -- requirements
Module: wsacc_window_gen

Interface
REQ-001 SHALL have parameter dataWidth, default 8: pixel/activation width in bits (unsigned).
REQ-002 SHALL have parameter maxWidth, default 32: maximum image row length in pixels, which sets the line-buffer depth.
REQ-003 SHALL have parameter windowElements, default 9: fixed 3x3 window size; other values are unsupported.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle frame-start pulse, honoured only in IDLE.
REQ-007 SHALL have port cfg_width, input, $clog2(maxWidth)+1 bits: image width W in pixels, sampled on an accepted start.
REQ-008 SHALL have port cfg_height, input, 16 bits: image height H in rows, sampled on an accepted start.
REQ-009 SHALL have port pix_valid, input, 1 bit: the upstream pixel is valid.
REQ-010 SHALL have port pix_i, input, dataWidth bits: pixel data, delivered in raster order (row-major, column 0 first).
REQ-011 SHALL have port pix_ready, output, 1 bit: the block accepts the pixel this cycle.
REQ-012 SHALL have port win_valid, output, 1 bit: window_o holds a valid window.
REQ-013 SHALL have port win_ready, input, 1 bit: downstream PE array consumes the window this cycle.
REQ-014 SHALL have port window_o, output, [windowElements-1:0][dataWidth-1:0]: the 3x3 window; element index is 3*r+c, with r=0 the oldest row and c=0 the leftmost column, matching the PE weight_addr order.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: single-cycle pulse at frame completion.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM and DONE.
REQ-018 IDLE->STREAM SHALL occur on start when 3<=cfg_width<=maxWidth and cfg_height>=3; this clears the col/row counters and latches W/H.
REQ-019 IDLE->DONE SHALL occur on start with an illegal cfg (W<3, W>maxWidth, or H<3); no pixels are accepted and no windows are produced.
REQ-020 A start pulse outside IDLE SHALL be ignored.
REQ-021 A pixel handshake SHALL occur when pix_valid && pix_ready; pix_ready = (state==STREAM) && !last_pix_taken && (!win_valid || win_ready).
REQ-022 Each accepted pixel at column c SHALL perform: new column = {lb2[c], lb1[c], pix_i}; lb2[c]<=lb1[c]; lb1[c]<=pix_i; the 3x3 register shifts one column left and the new column enters at c=2.
REQ-023 The col counter SHALL wrap from W-1 to 0 and increment row on wrap.
REQ-024 A window SHALL be emitted when the accepted pixel has row>=2 and col>=2; win_valid rises the next cycle (latency 1) with window_o = rows row-2..row, columns col-2..col.
REQ-025 win_valid and window_o SHALL hold stable until win_ready; a simultaneous win_ready plus new-window pixel acceptance replaces the window in the same cycle with no bubble.
REQ-026 Exactly (W-2)*(H-2) windows SHALL be emitted per frame; pixels with col<2 or row<2 only fill the buffers.
REQ-027 The last pixel SHALL be (row H-1, col W-1); after it, pix_ready stays low.
REQ-028 STREAM->DONE SHALL occur once the last window has been handshaken.
REQ-029 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-030 Line-buffer contents from a previous frame SHALL never appear in an emitted window; row<2 gating guarantees this, and no clear is required.
REQ-031 Widths SHALL be unsigned pass-through with no arithmetic on pixel data.
REQ-032 Counters SHALL be sized for maxWidth and 16-bit height with no overflow.

Reset
REQ-033 While rst is high, the block SHALL force: state=IDLE; pix_ready=0; win_valid=0; window_o=0; busy=0; done=0; counters=0.
REQ-034 Line-buffer memories SHALL need no reset.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; the first window after reset comes only from a new start.

Verification
REQ-036 W=4, H=3, pixels 1..12, win_ready=1 SHALL give two windows, {1,2,3,5,6,7,9,10,11} then {2,3,4,6,7,8,10,11,12}, each 1 cycle after pixels 11 and 12; done pulses once.
REQ-037 Same frame with win_ready=0 for 5 cycles after the first window SHALL hold win_valid=1 and window_o stable, keep pix_ready=0, and deliver the second window correctly after release.
REQ-038 W=32, H=4, random pixels, random pix_valid/win_ready SHALL give exactly 60 windows, each matching the golden 3x3 slice of the image.
REQ-039 cfg_width=2, H=5, start SHALL give done 1 cycle later, pix_ready never high, and 0 windows.
REQ-040 rst pulsed after 7 pixels of a W=4, H=3 frame SHALL clear all outputs; a new start with pixels 1..12 then gives the windows of REQ-036 exactly.
REQ-041 start asserted during STREAM SHALL be ignored, with no counter reset and the window sequence unchanged.

Source files
------------

// File: rtl/wsacc_window_gen_if.sv
// Pixel-stream / window handshake bundle for wsacc_window_gen.
// The master side is the frame source plus the PE-array consumer; the slave side is the window generator.
interface wsacc_window_gen_if #(
    parameter int unsigned dataWidth      = 8,
    parameter int unsigned maxWidth       = 32,
    parameter int unsigned windowElements = 9
);
    localparam int unsigned CfgW = $clog2(maxWidth) + 1;

    logic                                       start;
    logic [CfgW-1:0]                            cfg_width;
    logic [15:0]                                cfg_height;
    logic                                       pix_valid;
    logic [dataWidth-1:0]                       pix_i;
    logic                                       pix_ready;
    logic                                       win_valid;
    logic                                       win_ready;
    logic [windowElements-1:0][dataWidth-1:0]   window_o;
    logic                                       busy;
    logic                                       done;

    modport master (
        output start, cfg_width, cfg_height, pix_valid, pix_i, win_ready,
        input  pix_ready, win_valid, window_o, busy, done
    );

    modport slave (
        input  start, cfg_width, cfg_height, pix_valid, pix_i, win_ready,
        output pix_ready, win_valid, window_o, busy, done
    );
endinterface

// File: rtl/wsacc_window_gen.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift register turn a
// raster pixel stream into (W-2)*(H-2) windows for the weight-stationary PE array.
module wsacc_window_gen #(
    parameter int unsigned dataWidth      = 8,
    parameter int unsigned maxWidth       = 32,
    parameter int unsigned windowElements = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    wsacc_window_gen_if.slave     bus
);
    localparam int unsigned CW = $clog2(maxWidth) + 1;
    localparam int unsigned AW = $clog2(maxWidth);
    localparam int unsigned HW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [windowElements-1:0][dataWidth-1:0] win_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [HW-1:0]   row_q, row_d;
    logic [CW-1:0]   width_q, width_d;
    logic [HW-1:0]   height_q, height_d;
    logic            last_q, last_d;
    logic            win_valid_q, win_valid_d;
    win_t            win_q, win_d;
    win_t            sr_q, sr_d;

    logic [dataWidth-1:0] lb1_q [maxWidth];
    logic [dataWidth-1:0] lb2_q [maxWidth];

    logic [AW-1:0]        lb_idx;
    logic [dataWidth-1:0] lb1_rd, lb2_rd;
    win_t                 sr_shift;
    logic                 pix_ready_c;
    logic                 accept_c;
    logic                 cfg_ok_c;
    logic                 last_pix_c;

    assign lb_idx = col_q[AW-1:0];
    assign lb1_rd = lb1_q[lb_idx];
    assign lb2_rd = lb2_q[lb_idx];

    // A stalled window blocks every pixel so window_o cannot move under the consumer.
    assign pix_ready_c = (state_q == STREAM) && !last_q && (!win_valid_q || bus.win_ready);
    assign accept_c    = bus.pix_valid && pix_ready_c;
    assign cfg_ok_c    = (bus.cfg_width >= CW'(3)) && (bus.cfg_width <= CW'(maxWidth)) &&
                         (bus.cfg_height >= HW'(3));
    assign last_pix_c  = (row_q == height_q - HW'(1)) && (col_q == width_q - CW'(1));

    // Shift one column left; the new column is {oldest row, middle row, incoming pixel}.
    always_comb begin
        sr_shift      = sr_q;
        sr_shift[8:6] = {bus.pix_i, sr_q[8:7]};
        sr_shift[5:3] = {lb1_rd,    sr_q[5:4]};
        sr_shift[2:0] = {lb2_rd,    sr_q[2:1]};
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        width_d     = width_q;
        height_d    = height_q;
        last_d      = last_q;
        win_valid_d = win_valid_q;
        win_d       = win_q;
        sr_d        = sr_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (cfg_ok_c) begin
                        state_d  = STREAM;
                        col_d    = '0;
                        row_d    = '0;
                        width_d  = bus.cfg_width;
                        height_d = bus.cfg_height;
                        last_d   = 1'b0;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            STREAM: begin
                if (win_valid_q && bus.win_ready) begin
                    win_valid_d = 1'b0;
                end
                if (accept_c) begin
                    sr_d = sr_shift;
                    if ((row_q >= HW'(2)) && (col_q >= CW'(2))) begin
                        win_valid_d = 1'b1;
                        win_d       = sr_shift;
                    end
                    if (col_q == width_q - CW'(1)) begin
                        col_d = '0;
                        row_d = row_q + HW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_pix_c) begin
                        last_d = 1'b1;
                    end
                end
                if (last_q && (!win_valid_q || bus.win_ready)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            last_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
            sr_q        <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            width_q     <= width_d;
            height_q    <= height_d;
            last_q      <= last_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
            sr_q        <= sr_d;
        end
    end

    // Line buffers hold no reset: stale rows are never windowed because of the row>=2 gate.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb2_q[lb_idx] <= lb1_rd;
            lb1_q[lb_idx] <= bus.pix_i;
        end
    end

    assign bus.pix_ready = pix_ready_c;
    assign bus.win_valid = win_valid_q;
    assign bus.window_o  = win_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_wsacc_window_gen.sv
// Directed bench for wsacc_window_gen: small hand-checked frames, stall, reset abort,
// illegal configs, ignored start, and a randomized 32x4 frame against a golden image slice.
module tb_wsacc_window_gen;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Element 8 is the MSB; rows oldest-first, columns left-first.
    localparam logic [71:0] W1 = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
    localparam logic [71:0] W2 = {8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2};
    localparam logic [71:0] W3 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    logic [7:0] img [0:128];

    wsacc_window_gen_if #(.dataWidth(8), .maxWidth(32), .windowElements(9)) bus ();

    wsacc_window_gen #(.dataWidth(8), .maxWidth(32), .windowElements(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] gold(input int row, input int col, input int w);
        logic [8:0][7:0] g;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                g[3*r+c] = img[(row-2+r)*w + (col-2+c)];
        return g;
    endfunction

    // W=4 H=3 frame of pixels 1..12 with win_ready held high; glitch>0 pulses start before that pixel.
    task automatic run_frame(input int glitch);
        bus.cfg_width  = 6'd4;
        bus.cfg_height = 16'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_stream", bus.busy, 1);
        for (int p = 1; p <= 12; p++) begin
            if (p == glitch) begin
                bus.start     = 1'b1;
                bus.cfg_width = 6'd3;
            end
            bus.pix_valid = 1'b1;
            bus.pix_i     = 8'(p);
            bus.win_ready = 1'b1;
            #1;
            chk("pix_ready", bus.pix_ready, 1);
            tick();
            bus.start     = 1'b0;
            bus.cfg_width = 6'd4;
            if (p == 11) begin
                chk("win1_valid", bus.win_valid, 1);
                chk("win1_data", bus.window_o, W1);
            end else if (p == 12) begin
                chk("win2_valid", bus.win_valid, 1);
                chk("win2_data", bus.window_o, W2);
            end else begin
                chk("no_win", bus.win_valid, 0);
            end
        end
        bus.pix_valid = 1'b0;
        #1;
        chk("ready_after_last", bus.pix_ready, 0);
        tick();
        chk("done_pulse", bus.done, 1);
        chk("win_drained", bus.win_valid, 0);
        tick();
        chk("done_single", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        int         pidx;
        int         nwin;
        logic       seen_done;
        logic       acc;
        logic       hs;

        tests = 0;
        fails = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.cfg_width  = '0;
        bus.cfg_height = '0;
        bus.pix_valid  = 1'b0;
        bus.pix_i      = '0;
        bus.win_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_pix_ready", bus.pix_ready, 0);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_window", bus.window_o, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        tick();

        // Basic 4x3 frame
        run_frame(0);

        // Same frame with a 5-cycle consumer stall after the first window
        bus.cfg_width  = 6'd4;
        bus.cfg_height = 16'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int p = 1; p <= 11; p++) begin
            bus.pix_valid = 1'b1;
            bus.pix_i     = 8'(p);
            bus.win_ready = 1'b1;
            tick();
        end
        chk("stall_win1_valid", bus.win_valid, 1);
        chk("stall_win1_data", bus.window_o, W1);
        bus.win_ready = 1'b0;
        bus.pix_i     = 8'd12;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_ready_low", bus.pix_ready, 0);
            tick();
            chk("stall_hold_valid", bus.win_valid, 1);
            chk("stall_hold_data", bus.window_o, W1);
        end
        bus.win_ready = 1'b1;
        #1;
        chk("stall_release_ready", bus.pix_ready, 1);
        tick();
        chk("stall_win2_valid", bus.win_valid, 1);
        chk("stall_win2_data", bus.window_o, W2);
        bus.pix_valid = 1'b0;
        tick();
        chk("stall_done", bus.done, 1);
        tick();
        chk("stall_idle", bus.busy, 0);

        // Illegal width: W=2
        bus.cfg_width  = 6'd2;
        bus.cfg_height = 16'd5;
        bus.start      = 1'b1;
        bus.pix_valid  = 1'b1;
        #1;
        chk("ill_w2_ready_idle", bus.pix_ready, 0);
        tick();
        bus.start = 1'b0;
        chk("ill_w2_done", bus.done, 1);
        chk("ill_w2_ready", bus.pix_ready, 0);
        chk("ill_w2_nowin", bus.win_valid, 0);
        tick();
        chk("ill_w2_done_end", bus.done, 0);
        chk("ill_w2_idle", bus.busy, 0);

        // Illegal width above maxWidth, and illegal height
        bus.cfg_width  = 6'd33;
        bus.cfg_height = 16'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ill_w33_done", bus.done, 1);
        tick();
        bus.cfg_width  = 6'd4;
        bus.cfg_height = 16'd2;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ill_h2_done", bus.done, 1);
        chk("ill_h2_ready", bus.pix_ready, 0);
        tick();
        bus.pix_valid = 1'b0;

        // Smallest legal frame: 3x3 -> one window
        bus.cfg_width  = 6'd3;
        bus.cfg_height = 16'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int p = 1; p <= 9; p++) begin
            bus.pix_valid = 1'b1;
            bus.pix_i     = 8'(p);
            bus.win_ready = 1'b1;
            tick();
            chk("min_win_valid", bus.win_valid, (p == 9) ? 1 : 0);
        end
        chk("min_win_data", bus.window_o, W3);
        bus.pix_valid = 1'b0;
        tick();
        chk("min_done", bus.done, 1);
        tick();

        // Reset asserted mid-frame after 7 pixels
        bus.cfg_width  = 6'd4;
        bus.cfg_height = 16'd3;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int p = 1; p <= 7; p++) begin
            bus.pix_valid = 1'b1;
            bus.pix_i     = 8'(p);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("abort_ready", bus.pix_ready, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_window", bus.window_o, 0);
        chk("abort_win_valid", bus.win_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_restart", bus.pix_ready, 0);
        bus.pix_valid = 1'b0;
        run_frame(0);

        // start pulsed mid-frame is ignored
        run_frame(5);

        // Randomized 32x4 frame with random valid/ready
        for (int i = 0; i < 129; i++) img[i] = 8'($urandom_range(0, 255));
        pidx      = 0;
        nwin      = 0;
        seen_done = 1'b0;
        bus.cfg_width  = 6'd32;
        bus.cfg_height = 16'd4;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            bus.pix_valid = ($urandom_range(0, 3) != 0) && (pidx < 128);
            bus.pix_i     = img[pidx];
            bus.win_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = bus.pix_valid && bus.pix_ready;
            hs  = bus.win_valid && bus.win_ready;
            if (hs) begin
                if (nwin < 60) chk("rand_win", bus.window_o, gold(2 + nwin / 30, 2 + nwin % 30, 32));
                nwin++;
            end
            tick();
            if (acc) pidx++;
            if (bus.done) seen_done = 1'b1;
        end
        chk("rand_done_seen", seen_done, 1);
        chk("rand_win_count", 72'(nwin), 72'(60));
        chk("rand_pix_count", 72'(pidx), 72'(128));
        bus.pix_valid = 1'b0;
        tick();
        chk("rand_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
